// File: rtl/stream_rd_merge.sv
// Merges page-split read chunks back into one AXI R burst: counts beats per
// chunk, hides intermediate RLASTs, restores the original RID, flags mismatches.
module stream_rd_merge #(
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 16,
  parameter int CMD_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [8:0]            cmd_beats,
  input  logic                  cmd_last,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rlast,
  output logic                  m_rvalid,
  input  logic                  m_rready,
  output logic [ID_WIDTH-1:0]   m_rid,
  output logic [DATA_WIDTH-1:0] m_rdata,
  output logic [1:0]            m_rresp,
  output logic                  m_rlast,
  output logic                  err,
  output logic                  busy
);

  localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(CMD_DEPTH);

  logic [8:0]          beats_mem [CMD_DEPTH];
  logic                last_mem  [CMD_DEPTH];
  logic [ID_WIDTH-1:0] id_mem    [CMD_DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   occ;
  logic [8:0]       cnt;
  logic             full, empty, push, pop, beat, chunk_end;
  logic [8:0]       head_beats;
  logic             head_last;

  assign full       = (occ == FULL_CNT);
  assign empty      = (occ == '0);
  assign cmd_ready  = !full;
  assign push       = cmd_valid & !full;

  assign head_beats = beats_mem[rd_ptr];
  assign head_last  = last_mem[rd_ptr];

  // 9-bit subtraction wraps, so a beats field of 0 ends the chunk at cnt=511.
  assign chunk_end  = (cnt == head_beats - 9'd1);

  assign s_rready   = m_rready & !empty;
  assign m_rvalid   = s_rvalid & !empty;
  assign m_rdata    = s_rdata;
  assign m_rresp    = s_rresp;
  assign m_rid      = id_mem[rd_ptr];
  assign m_rlast    = !empty & chunk_end & head_last;

  assign beat       = s_rvalid & s_rready;
  assign pop        = beat & chunk_end;
  assign busy       = !empty | (cnt != 9'd0);

  // Descriptor storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      beats_mem[wr_ptr] <= cmd_beats;
      last_mem[wr_ptr]  <= cmd_last;
      id_mem[wr_ptr]    <= cmd_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (beat) cnt <= chunk_end ? 9'd0 : cnt + 9'd1;
      // Chunk boundaries follow the counter; s_rlast is only cross-checked.
      if (beat && (s_rlast != chunk_end)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_rd_merge.sv
// Scoreboard bench for stream_rd_merge: expected beats queued when driven,
// popped and compared when the merged R channel transfers them.
module tb_stream_rd_merge;

  localparam int DW = 512;
  localparam int IW = 16;
  localparam int CD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [8:0]    cmd_beats;
  logic          cmd_last;
  logic [IW-1:0] cmd_id;
  logic          s_rvalid;
  logic          s_rready;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rlast;
  logic          m_rvalid;
  logic          m_rready;
  logic [IW-1:0] m_rid;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rlast;
  logic          err;
  logic          busy;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic [IW-1:0] id;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  stream_rd_merge #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .CMD_DEPTH(CD)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_beats(cmd_beats),
    .cmd_last(cmd_last), .cmd_id(cmd_id),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .err(err), .busy(busy)
  );

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic push_cmd(input logic [8:0] b, input logic l, input logic [IW-1:0] id);
    bit done = 0;
    cmd_valid = 1'b1; cmd_beats = b; cmd_last = l; cmd_id = id;
    for (int w = 0; w < 50 && !done; w++) begin
      @(negedge clk);
      if (cmd_ready) done = 1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL push_cmd_timeout: cmd_ready stayed 0, required 1");
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [1:0] resp, input logic rl,
                           input logic [IW-1:0] eid, input logic el, output int waited);
    exp_t e, got;
    bit done = 0;
    e.data = d; e.resp = resp; e.id = eid; e.last = el;
    exp_q.push_back(e);
    s_rvalid = 1'b1; s_rdata = d; s_rresp = resp; s_rlast = rl;
    waited = 0;
    while (!done && waited < 50) begin
      @(negedge clk);
      if (s_rready) begin
        got = exp_q.pop_front();
        n_cmp++;
        if (m_rvalid !== 1'b1) begin n_err++; $display("FAIL beat_valid: got %b required 1", m_rvalid); end
        n_cmp++;
        if (m_rdata !== got.data) begin n_err++; $display("FAIL beat_data: got %h required %h", m_rdata, got.data); end
        n_cmp++;
        if (m_rid !== got.id) begin n_err++; $display("FAIL beat_id: got %h required %h", m_rid, got.id); end
        n_cmp++;
        if (m_rlast !== got.last) begin n_err++; $display("FAIL beat_last: got %b required %b", m_rlast, got.last); end
        n_cmp++;
        if (m_rresp !== got.resp) begin n_err++; $display("FAIL beat_resp: got %b required %b", m_rresp, got.resp); end
        done = 1;
      end else begin
        waited++;
      end
      @(posedge clk); #1;
    end
    s_rvalid = 1'b0; s_rlast = 1'b0;
    if (!done) begin
      void'(exp_q.pop_back());
      n_cmp++; n_err++;
      $display("FAIL beat_timeout: s_rready stayed 0, required 1");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_rvalid = 1'b1; m_rready = 1'b1; cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready: got %b required 1", cmd_ready); end
    n_cmp++; if (s_rready !== 1'b0) begin n_err++; $display("FAIL rst_s_rready: got %b required 0", s_rready); end
    n_cmp++; if (m_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_m_rvalid: got %b required 0", m_rvalid); end
    n_cmp++; if (m_rlast !== 1'b0) begin n_err++; $display("FAIL rst_m_rlast: got %b required 0", m_rlast); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b required 0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b required 0", err); end
    @(negedge clk); rst_n = 1'b1; s_rvalid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int w, wsum = 0;
    push_cmd(9'd4, 1'b1, 16'h0005);
    for (int i = 0; i < 4; i++) begin
      send_beat(rnd_data(), 2'(i), (i == 3), 16'h0005, (i == 3), w);
      wsum += w;
    end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL single_err: got %b required 0", err); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy: got %b required 0", busy); end
  endtask

  task automatic test_page_split();
    int w, wsum = 0;
    push_cmd(9'd2, 1'b0, 16'h0007);
    push_cmd(9'd3, 1'b1, 16'h0007);
    for (int i = 0; i < 5; i++) begin
      send_beat(rnd_data(), 2'b00, (i == 1 || i == 4), 16'h0007, (i == 4), w);
      wsum += w;
    end
    n_cmp++; if (wsum !== 0) begin n_err++; $display("FAIL split_bubble: got %0d stall cycles required 0", wsum); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL split_busy: got %b required 0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL split_err: got %b required 0", err); end
  endtask

  task automatic test_full_page();
    int w, wsum = 0;
    push_cmd(9'd0, 1'b1, 16'h0009);
    for (int i = 0; i < 512; i++) begin
      send_beat(rnd_data(), 2'b01, (i == 511), 16'h0009, (i == 511), w);
      wsum += w;
      if (i == 100) begin
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL page_busy_mid: got %b required 1", busy); end
      end
    end
    n_cmp++; if (wsum !== 0) begin n_err++; $display("FAIL page_stall: got %0d required 0", wsum); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL page_busy_end: got %b required 0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL page_err: got %b required 0", err); end
  endtask

  task automatic test_backpressure();
    int w, stall_bad = 0;
    logic [DW-1:0] d;
    exp_t got;
    push_cmd(9'd4, 1'b1, 16'h0003);
    send_beat(rnd_data(), 2'b00, 1'b0, 16'h0003, 1'b0, w);
    send_beat(rnd_data(), 2'b00, 1'b0, 16'h0003, 1'b0, w);
    m_rready = 1'b0; s_rvalid = 1'b1; s_rdata = rnd_data(); s_rlast = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s_rready !== 1'b0 || m_rvalid !== 1'b1) stall_bad++;
      @(posedge clk); #1;
    end
    n_cmp++; if (stall_bad !== 0) begin n_err++; $display("FAIL bp_stall: got %0d bad cycles required 0", stall_bad); end
    m_rready = 1'b1;
    send_beat(rnd_data(), 2'b00, 1'b0, 16'h0003, 1'b0, w);
    send_beat(rnd_data(), 2'b00, 1'b1, 16'h0003, 1'b1, w);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_busy: got %b required 0", busy); end
    for (int i = 0; i < CD; i++) push_cmd(9'd1, 1'b1, 16'(16'h0100 + i));
    cmd_valid = 1'b1; cmd_beats = 9'd1; cmd_last = 1'b1; cmd_id = 16'hDEAD;
    d = rnd_data();
    got.data = d; got.resp = 2'b10; got.id = 16'h0100; got.last = 1'b1;
    exp_q.push_back(got);
    s_rvalid = 1'b1; s_rdata = d; s_rresp = 2'b10; s_rlast = 1'b1;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL full_pop_cmd_ready: got %b required 0", cmd_ready); end
    n_cmp++; if (s_rready !== 1'b1) begin n_err++; $display("FAIL full_s_rready: got %b required 1", s_rready); end
    got = exp_q.pop_front();
    n_cmp++; if (m_rid !== got.id) begin n_err++; $display("FAIL full_beat_id: got %h required %h", m_rid, got.id); end
    n_cmp++; if (m_rlast !== got.last) begin n_err++; $display("FAIL full_beat_last: got %b required %b", m_rlast, got.last); end
    @(posedge clk); #1;
    cmd_valid = 1'b0; s_rvalid = 1'b0;
    for (int i = 1; i < CD; i++)
      send_beat(rnd_data(), 2'b00, 1'b1, 16'(16'h0100 + i), 1'b1, w);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fill_drain_busy: got %b required 0 (extra descriptor accepted?)", busy); end
  endtask

  task automatic test_mismatch();
    int w;
    push_cmd(9'd3, 1'b1, 16'h000A);
    send_beat(rnd_data(), 2'b00, 1'b0, 16'h000A, 1'b0, w);
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL mis_err_before: got %b required 0", err); end
    send_beat(rnd_data(), 2'b00, 1'b1, 16'h000A, 1'b0, w);
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL mis_err_set: got %b required 1", err); end
    send_beat(rnd_data(), 2'b00, 1'b1, 16'h000A, 1'b1, w);
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL mis_err_held: got %b required 1", err); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mis_busy: got %b required 0", busy); end
  endtask

  task automatic test_reset_mid();
    int w;
    push_cmd(9'd4, 1'b1, 16'h000B);
    send_beat(rnd_data(), 2'b00, 1'b0, 16'h000B, 1'b0, w);
    send_beat(rnd_data(), 2'b00, 1'b0, 16'h000B, 1'b0, w);
    s_rvalid = 1'b1; s_rlast = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rmid_cmd_ready: got %b required 1", cmd_ready); end
    n_cmp++; if (s_rready !== 1'b0) begin n_err++; $display("FAIL rmid_s_rready: got %b required 0", s_rready); end
    n_cmp++; if (m_rvalid !== 1'b0) begin n_err++; $display("FAIL rmid_m_rvalid: got %b required 0", m_rvalid); end
    n_cmp++; if (m_rlast !== 1'b0) begin n_err++; $display("FAIL rmid_m_rlast: got %b required 0", m_rlast); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b required 0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rmid_err: got %b required 0", err); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (m_rvalid !== 1'b0) begin n_err++; $display("FAIL rmid_no_beat: got %b required 0", m_rvalid); end
    s_rvalid = 1'b0;
    push_cmd(9'd1, 1'b1, 16'h000C);
    send_beat(rnd_data(), 2'b11, 1'b1, 16'h000C, 1'b1, w);
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rmid_fresh_err: got %b required 0", err); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_fresh_busy: got %b required 0", busy); end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_beats = '0; cmd_last = 1'b0; cmd_id = '0;
    s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; m_rready = 1'b1;
    test_reset();
    test_single();
    test_page_split();
    test_full_page();
    test_backpressure();
    test_mismatch();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_leftover: got %0d required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stream_rd_merge.md
# stream_rd_merge

Reassembles page-split read responses into a single AXI read burst toward the original requester. The stream command generator splits one AR burst into page-bounded chunks. This block runs on the return path: it tracks each chunk's beat count, suppresses the per-chunk RLAST of every non-final chunk, restores the original RID, and flags protocol mismatches. It sits between the per-page stream engine's R output and the shield's upstream AXI R channel.

## Interface
- DATA_WIDTH, 512, R data width in bits
- ID_WIDTH, 16, RID width
- CMD_DEPTH, 4, chunk-command FIFO entries (power of 2, ≥2)

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  chunk descriptor valid
- cmd_ready  out  1  descriptor accepted when valid&ready
- cmd_beats  in  9  beats in this chunk; 0 encodes 512
- cmd_last  in  1  chunk is the final chunk of the original burst
- cmd_id  in  ID_WIDTH  original ARID
- s_rvalid  in  1  chunk-side beat valid
- s_rready  out  1  chunk-side beat ready
- s_rdata  in  DATA_WIDTH  beat data
- s_rresp  in  2  beat response
- s_rlast  in  1  chunk-side last (used only for checking)
- m_rvalid  out  1  upstream beat valid
- m_rready  in  1  upstream ready
- m_rid  out  ID_WIDTH  head descriptor's cmd_id
- m_rdata  out  DATA_WIDTH  = s_rdata
- m_rresp  out  2  = s_rresp (per-beat, unmodified)
- m_rlast  out  1  last beat of the original burst
- err  out  1  sticky protocol-error flag
- busy  out  1  FIFO non-empty or mid-chunk

## Operation
- Descriptor FIFO (CMD_DEPTH entries of {beats, last, id}): push on cmd_valid&cmd_ready; cmd_ready = !full. A push is never bypassed, and full+pop in the same cycle still deasserts cmd_ready.
- Head descriptor defines the current chunk. The 9-bit beat counter `cnt` starts at 0.
- Pass-through, combinational: m_rvalid = s_rvalid & !empty; s_rready = m_rready & !empty. Beats arriving while the FIFO is empty stall.
- chunk_end = (cnt == head.beats − 1), computed mod 512, so beats=0 ends at cnt=511.
- m_rlast = chunk_end & head.last.
- On a beat transfer (s_rvalid & s_rready):
  - If chunk_end: pop the head and set cnt←0.
  - Otherwise: cnt←cnt+1.
- Chunk boundaries come only from the counter, never from s_rlast.
- Error checks (each sets err, held until reset; data flow continues unaffected):
  - transferred beat with s_rlast ≠ chunk_end;
  - descriptor pushed while full (cmd_valid&!cmd_ready is not an error; a push attempt cannot occur).
- busy = !empty | (cnt ≠ 0).

## Timing
- Data path has zero latency: m_* are driven combinationally from s_* and the FIFO head. No registers sit in the data path.
- A descriptor pushed in cycle N is visible at the head in cycle N+1. A beat in cycle N is stalled if the FIFO was empty at the start of N.
- A pop on cycle N exposes the next descriptor at cycle N+1. Back-to-back chunks stream with no bubble when the next descriptor is already queued.
- Reset (asynchronous assert, synchronous-release use): FIFO empty, cnt=0, err=0. Output values under reset:
  - cmd_ready=1
  - s_rready=0, m_rvalid=0, m_rlast=0
  - busy=0
- Reset mid-burst discards all queued descriptors and partial counts. No beat is emitted until a new descriptor is pushed.
- Simultaneous push and pop in one cycle: both take effect, and occupancy is unchanged.

## Test plan
- Single aligned chunk: push {beats=4, last=1, id=0x5}, then send 4 beats with s_rlast on beat 4. Expect 4 m_r beats with m_rid=0x5, m_rlast only on beat 4, and err=0.
- Page split: push {beats=2, last=0, id=7} and {beats=3, last=1, id=7}, then send 5 beats with s_rlast on beats 2 and 5. Expect m_rlast only on beat 5, no bubble between chunks, and busy=0 afterward.
- Full page: push {beats=0 (512), last=1}, then send 512 beats. Expect m_rlast on beat 512, the pop after it, and cnt back at 0.
- Backpressure and flow: hold m_rready=0 for 10 cycles mid-chunk. Expect s_rready=0, the counter frozen, and no lost or duplicated beats. Fill the FIFO to CMD_DEPTH and expect cmd_ready=0.
- Mismatch: push beats=3 and assert s_rlast on beat 2. Expect err=1 from the next cycle, held, while the chunk still ends at beat 3.
- Reset mid-chunk: deassert rst_n after 2 of 4 beats. Expect every output at its reset value, then a fresh {beats=1, last=1} to complete correctly.
